// File: rtl/dff_pipe_pkg.sv
// ============================================================================
// Module   : dff_pipe_pkg
// Desc     : Shared helpers and defaults for the dff_pipe delay line.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dff_pipe_pkg;

  localparam logic c_rst_bit = 1'b0;

  // Width needed to count 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dff_en_stage.sv
// ============================================================================
// Module   : dff_en_stage
// Desc     : One enabled register stage carrying data plus its valid bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dff_en_stage
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{c_rst_bit}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  logic [WIDTH:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= {1'b0, RST_VAL};
    end else if (clr) begin
      r_word <= {1'b0, RST_VAL};
    end else if (en) begin
      r_word <= {vld, d};
    end
  end

  assign q     = r_word[WIDTH-1:0];
  assign q_vld = r_word[WIDTH];

endmodule

`default_nettype wire

// File: rtl/dff_pipe.sv
// ============================================================================
// Module   : dff_pipe
// Desc     : Enabled WIDTH x DEPTH delay line with valid tracking and fill count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{c_rst_bit}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [WIDTH-1:0]          d,
  input  logic                      d_vld,
  output logic [WIDTH-1:0]          q,
  output logic                      q_vld,
  output logic [cnt_w(DEPTH)-1:0]   fill_cnt,
  output logic                      out_pulse
);

  localparam int CW = cnt_w(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_pipe: WIDTH must be at least 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] w_data [DEPTH];
  logic [DEPTH-1:0] w_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] w_d_in;
    logic             w_v_in;

    if (i == 0) begin : g_head
      assign w_d_in = d;
      assign w_v_in = d_vld;
    end else begin : g_link
      assign w_d_in = w_data[i-1];
      assign w_v_in = w_vld[i-1];
    end

    dff_en_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .clr   (clr),
      .d     (w_d_in),
      .vld   (w_v_in),
      .q     (w_data[i]),
      .q_vld (w_vld[i])
    );
  end

  logic [CW-1:0] r_fill;
  logic          r_pulse;

  // Incremental count: the word entering and the word leaving are both known
  // before the edge, so no popcount over the stages is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill  <= '0;
      r_pulse <= 1'b0;
    end else if (clr) begin
      r_fill  <= '0;
      r_pulse <= 1'b0;
    end else if (en) begin
      r_fill  <= r_fill + CW'(d_vld) - CW'(w_vld[DEPTH-1]);
      r_pulse <= w_vld[DEPTH-1];
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign q         = w_data[DEPTH-1];
  assign q_vld     = w_vld[DEPTH-1];
  assign fill_cnt  = r_fill;
  assign out_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_dff_pipe.sv
// ============================================================================
// Module   : tb_dff_pipe
// Desc     : Self-checking bench for dff_pipe (DEPTH=4 and DEPTH=1 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dff_pipe;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, d_vld;
  logic [7:0] d;
  logic [7:0] q;
  logic       q_vld, out_pulse;
  logic [2:0] fill_cnt;

  logic       en1, clr1, d_vld1;
  logic [7:0] d1;
  logic [7:0] q1;
  logic       q_vld1, out_pulse1;
  logic [0:0] fill_cnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(DEPTH), .RST_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
    .q(q), .q_vld(q_vld), .fill_cnt(fill_cnt), .out_pulse(out_pulse)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .clr(clr1), .d(d1), .d_vld(d_vld1),
    .q(q1), .q_vld(q_vld1), .fill_cnt(fill_cnt1), .out_pulse(out_pulse1)
  );

  // Reference: the pipe is a list of DEPTH (data, valid) slots, newest first.
  logic [7:0] m_d[$];
  logic       m_v[$];
  logic       m_pulse;

  function automatic int m_fill();
    int n = 0;
    foreach (m_v[i]) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic m_reset();
    m_d.delete(); m_v.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_d.push_back(8'h00); m_v.push_back(1'b0);
    end
    m_pulse = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".q"},     32'(q),         32'(m_d[DEPTH-1]));
    chk({tag, ".q_vld"}, 32'(q_vld),     32'(m_v[DEPTH-1]));
    chk({tag, ".fill"},  32'(fill_cnt),  32'(m_fill()));
    chk({tag, ".pulse"}, 32'(out_pulse), 32'(m_pulse));
  endtask

  // Drive one cycle on the DEPTH=4 DUT, advance the model, compare after the edge.
  task automatic cycle(input logic e, input logic c, input logic [7:0] dd, input logic dv,
                       input string tag);
    en = e; clr = c; d = dd; d_vld = dv;
    @(posedge clk);
    if (c) begin
      m_reset();
    end else if (e) begin
      m_pulse = m_v[DEPTH-1];
      m_d.push_front(dd); m_v.push_front(dv);
      void'(m_d.pop_back()); void'(m_v.pop_back());
    end else begin
      m_pulse = 1'b0;
    end
    #1;
    chk_model(tag);
  endtask

  typedef struct {
    logic       en, clr;
    logic [7:0] d;
    logic       dv;
    logic [7:0] q;
    logic       qv;
    logic [2:0] fill;
    logic       pulse;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic c, logic [7:0] dd, logic dv,
                              logic [7:0] eq, logic eqv, logic [2:0] ef, logic ep);
    vec_t v;
    v.en = e; v.clr = c; v.d = dd; v.dv = dv;
    v.q = eq; v.qv = eqv; v.fill = ef; v.pulse = ep;
    return v;
  endfunction

  initial begin
    // Steady fill, then clear racing an enabled valid word.
    vecs.push_back(mk(1, 0, 8'h11, 1, 8'h00, 0, 3'd1, 0));
    vecs.push_back(mk(1, 0, 8'h22, 1, 8'h00, 0, 3'd2, 0));
    vecs.push_back(mk(1, 0, 8'h33, 1, 8'h00, 0, 3'd3, 0));
    vecs.push_back(mk(1, 0, 8'h44, 1, 8'h11, 1, 3'd4, 0));
    vecs.push_back(mk(1, 0, 8'h55, 1, 8'h22, 1, 3'd4, 1));
    vecs.push_back(mk(1, 1, 8'hFF, 1, 8'h00, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0));
    // Bubbles.
    vecs.push_back(mk(1, 0, 8'hA0, 1, 8'h00, 0, 3'd1, 0));
    vecs.push_back(mk(1, 0, 8'hA1, 0, 8'h00, 0, 3'd1, 0));
    vecs.push_back(mk(1, 0, 8'hA2, 1, 8'h00, 0, 3'd2, 0));
    vecs.push_back(mk(1, 0, 8'hA3, 0, 8'hA0, 1, 3'd2, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'hA1, 0, 3'd1, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'hA2, 1, 3'd1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'hA3, 0, 3'd0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 3'd0, 0));

    rst = 1'b1; en = 0; clr = 0; d = '0; d_vld = 0;
    en1 = 0; clr1 = 0; d1 = '0; d_vld1 = 0;
    m_reset();
    #3;
    chk("rst.q", 32'(q), 32'h00);
    chk("rst.q_vld", 32'(q_vld), 32'h0);
    chk("rst.fill", 32'(fill_cnt), 32'h0);
    chk("rst.pulse", 32'(out_pulse), 32'h0);
    chk("rst.d1_fill", 32'(fill_cnt1), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].clr, vecs[i].d, vecs[i].dv, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tq", i),     32'(q),         32'(vecs[i].q));
      chk($sformatf("vec%0d.tqv", i),    32'(q_vld),     32'(vecs[i].qv));
      chk($sformatf("vec%0d.tfill", i),  32'(fill_cnt),  32'(vecs[i].fill));
      chk($sformatf("vec%0d.tpulse", i), 32'(out_pulse), 32'(vecs[i].pulse));
    end

    // Enable gaps: disabled cycles do not count toward latency.
    cycle(1, 0, 8'h11, 1, "gap.e1");
    cycle(1, 0, 8'h22, 1, "gap.e2");
    cycle(0, 0, 8'hEE, 1, "gap.h1");
    chk("gap.hold_fill", 32'(fill_cnt), 32'd2);
    cycle(0, 0, 8'hEE, 1, "gap.h2");
    chk("gap.hold_qv", 32'(q_vld), 32'd0);
    cycle(1, 0, 8'h33, 1, "gap.e3");
    chk("gap.e3_qv", 32'(q_vld), 32'd0);
    cycle(1, 0, 8'h44, 1, "gap.e4");
    chk("gap.e4_q", 32'(q), 32'h11);
    chk("gap.e4_qv", 32'(q_vld), 32'd1);

    // Asynchronous reset mid-stream.
    cycle(0, 1, 8'h00, 0, "ar.clr");
    cycle(1, 0, 8'h61, 1, "ar.f1");
    cycle(1, 0, 8'h62, 1, "ar.f2");
    cycle(1, 0, 8'h63, 1, "ar.f3");
    chk("ar.pre_fill", 32'(fill_cnt), 32'd3);
    #1 rst = 1'b1;
    #1;
    m_reset();
    chk("ar.q", 32'(q), 32'h00);
    chk("ar.q_vld", 32'(q_vld), 32'h0);
    chk("ar.fill", 32'(fill_cnt), 32'h0);
    #1 rst = 1'b0;
    cycle(1, 0, 8'h77, 1, "ar.resume");
    chk("ar.resume_fill", 32'(fill_cnt), 32'd1);

    // Randomized stream against the model.
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 16) == 0, 8'($urandom), 1'($urandom),
            $sformatf("rnd%0d", i));
    end

    // DEPTH=1 build.
    en = 0; clr = 0;
    en1 = 1; d1 = 8'h5A; d_vld1 = 1;
    @(posedge clk); #1;
    chk("d1.q", 32'(q1), 32'h5A);
    chk("d1.q_vld", 32'(q_vld1), 32'h1);
    chk("d1.fill", 32'(fill_cnt1), 32'h1);
    chk("d1.pulse0", 32'(out_pulse1), 32'h0);
    d1 = 8'h00; d_vld1 = 0;
    @(posedge clk); #1;
    chk("d1.fill_out", 32'(fill_cnt1), 32'h0);
    chk("d1.pulse", 32'(out_pulse1), 32'h1);
    chk("d1.q_vld_out", 32'(q_vld1), 32'h0);
    en1 = 0;
    @(posedge clk); #1;
    chk("d1.pulse_off", 32'(out_pulse1), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
